// File: rtl/jtag_tap_core.sv
// IEEE 1149.1-style TAP controller with IR, BYPASS, optional IDCODE (macro TAP_IDCODE_EN) and one user DR.
// Latency: STATE/IR/USER_DR registered on posedge TCK; TDO is combinational from current state and shift regs.
// Backpressure: none; TMS/TDI are consumed on every TCK edge, USER_UPD is a one-cycle unacknowledged pulse.
module jtag_tap_core #(
  parameter int unsigned IR_W       = 4,
  parameter int unsigned DR_W       = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5001
) (
  input  logic            TCK,
  input  logic            TRST_N,
  input  logic            TMS,
  input  logic            TDI,
  input  logic [DR_W-1:0] USER_CAP,
  output logic            TDO,
  output logic            TDO_EN,
  output logic [3:0]      STATE,
  output logic [IR_W-1:0] IR,
  output logic [DR_W-1:0] USER_DR,
  output logic            USER_UPD
);

  typedef enum logic [3:0] {
    TLR      = 4'h0,
    RTI      = 4'h1,
    SEL_DR   = 4'h2,
    CAP_DR   = 4'h3,
    SHIFT_DR = 4'h4,
    EXIT1_DR = 4'h5,
    PAUSE_DR = 4'h6,
    EXIT2_DR = 4'h7,
    UPD_DR   = 4'h8,
    SEL_IR   = 4'h9,
    CAP_IR   = 4'hA,
    SHIFT_IR = 4'hB,
    EXIT1_IR = 4'hC,
    PAUSE_IR = 4'hD,
    EXIT2_IR = 4'hE,
    UPD_IR   = 4'hF
  } tap_state_e;

  localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(1);
  localparam logic [IR_W-1:0] OP_USER   = IR_W'(2);
`ifdef TAP_IDCODE_EN
  localparam logic [IR_W-1:0] RST_IR    = OP_IDCODE;
`else
  localparam logic [IR_W-1:0] RST_IR    = '1;
`endif

  // IDCODE bit 0 is the mandatory 1149.1 marker; an illegal value shows up as this named scope
  if (IDCODE_VAL[0] != 1'b1) begin : g_idcode_lsb_not_set
  end

  tap_state_e      state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [IR_W-1:0] ir_sr_q, ir_sr_d;
  logic            byp_q, byp_d;
  logic [DR_W-1:0] usr_sr_q, usr_sr_d;
  logic [DR_W-1:0] user_dr_q, user_dr_d;
  logic            user_upd_q, user_upd_d;
  logic [IR_W:0]   ir_shift_w;
  logic [DR_W:0]   usr_shift_w;
  logic            sel_usr;
  logic            sel_id;
  logic            id_tdo;

  assign sel_usr     = (ir_q == OP_USER);
  assign ir_shift_w  = {TDI, ir_sr_q};
  assign usr_shift_w = {TDI, usr_sr_q};

`ifdef TAP_IDCODE_EN
  logic [31:0] id_sr_q, id_sr_d;

  assign sel_id = (ir_q == OP_IDCODE);
  assign id_tdo = id_sr_q[0];

  // IDCODE shift register: capture constant, shift right with TDI at the MSB, otherwise hold
  always_comb begin
    id_sr_d = id_sr_q;
    if (sel_id) begin
      if (state_q == CAP_DR) begin
        id_sr_d = IDCODE_VAL;
      end else if (state_q == SHIFT_DR) begin
        id_sr_d = {TDI, id_sr_q[31:1]};
      end
    end
  end

  // IDCODE register flop
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      id_sr_q <= '0;
    end else begin
      id_sr_q <= id_sr_d;
    end
  end
`else
  assign sel_id = 1'b0;
  assign id_tdo = 1'b0;
`endif

  // Standard 1149.1 next-state function on TMS
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:      state_d = TMS ? TLR      : RTI;
      RTI:      state_d = TMS ? SEL_DR   : RTI;
      SEL_DR:   state_d = TMS ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = TMS ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_d = TMS ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_d = TMS ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = TMS ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_d = TMS ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_d = TMS ? SEL_DR   : RTI;
      SEL_IR:   state_d = TMS ? TLR      : CAP_IR;
      CAP_IR:   state_d = TMS ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_d = TMS ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_d = TMS ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = TMS ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_d = TMS ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_d = TMS ? SEL_DR   : RTI;
      default:  state_d = TLR;
    endcase
  end

  // Per-state datapath actions; anything not named by the current state holds its value
  always_comb begin
    ir_d       = ir_q;
    ir_sr_d    = ir_sr_q;
    byp_d      = byp_q;
    usr_sr_d   = usr_sr_q;
    user_dr_d  = user_dr_q;
    user_upd_d = 1'b0;
    case (state_q)
      TLR:      ir_d    = RST_IR;
      CAP_IR:   ir_sr_d = IR_W'(2'b01);
      SHIFT_IR: ir_sr_d = ir_shift_w[IR_W:1];
      UPD_IR:   ir_d    = ir_sr_q;
      CAP_DR: begin
        if (sel_usr) begin
          usr_sr_d = USER_CAP;
        end else if (!sel_id) begin
          byp_d = 1'b0;
        end
      end
      SHIFT_DR: begin
        if (sel_usr) begin
          usr_sr_d = usr_shift_w[DR_W:1];
        end else if (!sel_id) begin
          byp_d = TDI;
        end
      end
      UPD_DR: begin
        if (sel_usr) begin
          user_dr_d  = usr_sr_q;
          user_upd_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // TAP state machine and its registered outputs
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      state_q    <= TLR;
      ir_q       <= RST_IR;
      ir_sr_q    <= '0;
      byp_q      <= 1'b0;
      usr_sr_q   <= '0;
      user_dr_q  <= '0;
      user_upd_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_sr_q    <= ir_sr_d;
      byp_q      <= byp_d;
      usr_sr_q   <= usr_sr_d;
      user_dr_q  <= user_dr_d;
      user_upd_q <= user_upd_d;
    end
  end

  // Serial output mux: LSB of whichever register is currently shifting
  always_comb begin
    TDO = 1'b0;
    if (state_q == SHIFT_IR) begin
      TDO = ir_sr_q[0];
    end else if (state_q == SHIFT_DR) begin
      if (sel_usr) begin
        TDO = usr_sr_q[0];
      end else if (sel_id) begin
        TDO = id_tdo;
      end else begin
        TDO = byp_q;
      end
    end
  end

  assign TDO_EN   = (state_q == SHIFT_DR) || (state_q == SHIFT_IR);
  assign STATE    = state_q;
  assign IR       = ir_q;
  assign USER_DR  = user_dr_q;
  assign USER_UPD = user_upd_q;

endmodule

// File: tb/tb_jtag_tap_core.sv
// Bench for jtag_tap_core: bit-queue reference model checked every TCK, plus literal scan results.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
// Builds with or without TAP_IDCODE_EN; the expected reset instruction follows the macro.
module tb_jtag_tap_core;

  localparam int IR_W = 4;
  localparam int DR_W = 8;
`ifdef TAP_IDCODE_EN
  localparam bit              ID_EN  = 1'b1;
  localparam logic [IR_W-1:0] RST_IR = 4'b0001;
`else
  localparam bit              ID_EN  = 1'b0;
  localparam logic [IR_W-1:0] RST_IR = 4'b1111;
`endif

  logic            TCK, TRST_N, TMS, TDI;
  logic [DR_W-1:0] USER_CAP;
  logic            TDO, TDO_EN, USER_UPD;
  logic [3:0]      STATE;
  logic [IR_W-1:0] IR;
  logic [DR_W-1:0] USER_DR;

  jtag_tap_core #(.IR_W(IR_W), .DR_W(DR_W), .IDCODE_VAL(32'h1234_5001)) dut (
    .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI), .USER_CAP(USER_CAP),
    .TDO(TDO), .TDO_EN(TDO_EN), .STATE(STATE), .IR(IR), .USER_DR(USER_DR),
    .USER_UPD(USER_UPD)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  int n_cmp = 0;
  int n_bad = 0;
  int upd_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transition tables indexed by state number, one per TMS value.
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 11 - 1, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int              m_st;
  logic [IR_W-1:0] m_ir;
  logic [DR_W-1:0] m_udr;
  logic            m_upd;
  bit              m_on = 1'b0;
  // Each shift register is a queue of bits, front = bit that TDO presents next.
  bit q_ir[$];
  bit q_byp[$];
  bit q_id[$];
  bit q_usr[$];

  // 0 = IR, 1 = BYPASS, 2 = IDCODE, 3 = USER
  task automatic q_load(input int which, input logic [31:0] v, input int w);
    case (which)
      0: begin q_ir.delete();  for (int i = 0; i < w; i++) q_ir.push_back(v[i]);  end
      1: begin q_byp.delete(); for (int i = 0; i < w; i++) q_byp.push_back(v[i]); end
      2: begin q_id.delete();  for (int i = 0; i < w; i++) q_id.push_back(v[i]);  end
      default: begin q_usr.delete(); for (int i = 0; i < w; i++) q_usr.push_back(v[i]); end
    endcase
  endtask

  task automatic q_shift(input int which, input bit tdi);
    case (which)
      0: begin void'(q_ir.pop_front());  q_ir.push_back(tdi);  end
      1: begin void'(q_byp.pop_front()); q_byp.push_back(tdi); end
      2: begin void'(q_id.pop_front());  q_id.push_back(tdi);  end
      default: begin void'(q_usr.pop_front()); q_usr.push_back(tdi); end
    endcase
  endtask

  function automatic bit q_front(input int which);
    case (which)
      0: return q_ir[0];
      1: return q_byp[0];
      2: return q_id[0];
      default: return q_usr[0];
    endcase
  endfunction

  function automatic logic [31:0] q_pack(input int which);
    logic [31:0] r = '0;
    case (which)
      0: for (int i = 0; i < q_ir.size(); i++) r[i] = q_ir[i];
      default: for (int i = 0; i < q_usr.size(); i++) r[i] = q_usr[i];
    endcase
    return r;
  endfunction

  function automatic int m_sel();
    if (m_ir == 4'd2) return 3;
    if (ID_EN && m_ir == 4'd1) return 2;
    return 1;
  endfunction

  task automatic model_reset();
    m_st  = 0;
    m_ir  = RST_IR;
    m_udr = '0;
    m_upd = 1'b0;
    q_load(0, 0, IR_W);
    q_load(1, 0, 1);
    q_load(2, 0, 32);
    q_load(3, 0, DR_W);
  endtask

  task automatic model_step(input bit tms, input bit tdi);
    int  sel = m_sel();
    bit  upd = 1'b0;
    case (m_st)
      0:  m_ir = RST_IR;
      10: q_load(0, 1, IR_W);
      11: q_shift(0, tdi);
      15: m_ir = q_pack(0);
      3: begin
        if (sel == 3)      q_load(3, 32'(USER_CAP), DR_W);
        else if (sel == 2) q_load(2, 32'h1234_5001, 32);
        else               q_load(1, 0, 1);
      end
      4: q_shift(sel, tdi);
      8: if (sel == 3) begin m_udr = q_pack(3); upd = 1'b1; end
      default: ;
    endcase
    m_upd = upd;
    m_st  = tms ? nxt1[m_st] : nxt0[m_st];
  endtask

  function automatic bit exp_tdo();
    if (m_st == 11) return q_front(0);
    if (m_st == 4)  return q_front(m_sel());
    return 1'b0;
  endfunction

  // Per-cycle comparison of every output against the model
  always @(negedge TCK) begin
    if (m_on) begin
      check("state",    32'(STATE),    32'(m_st));
      check("ir",       32'(IR),       32'(m_ir));
      check("user_dr",  32'(USER_DR),  32'(m_udr));
      check("user_upd", 32'(USER_UPD), 32'(m_upd));
      check("tdo",      32'(TDO),      32'(exp_tdo()));
      check("tdo_en",   32'(TDO_EN),   32'((m_st == 4) || (m_st == 11)));
      upd_seen += int'(USER_UPD);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit tms, input bit tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    model_step(tms, tdi);
    @(negedge TCK);
  endtask

  // From RTI: full DR scan of n bits, ending back in RTI just after UPDATE_DR
  task automatic dr_scan(input int n, input logic [31:0] data, output logic [31:0] got);
    got = '0;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < n; i++) begin
      got[i] = TDO;
      step(i == n - 1, data[i]);
    end
    step(1, 0); step(0, 0);
  endtask

  // From RTI: full IR scan, ending back in RTI just after UPDATE_IR
  task automatic ir_scan(input logic [IR_W-1:0] op, output logic [31:0] got);
    got = '0;
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < IR_W; i++) begin
      got[i] = TDO;
      step(i == IR_W - 1, op[i]);
    end
    step(1, 0); step(0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got;
    logic [7:0]  pd;
    TRST_N   = 1'b1;
    TMS      = 1'b1;
    TDI      = 1'b0;
    USER_CAP = '0;
    #1 TRST_N = 1'b0;
    model_reset();
    m_on = 1'b1;
    @(negedge TCK);
    #2 TRST_N = 1'b1;

    check("rst_state",    32'(STATE),    32'h0);
    check("rst_ir",       32'(IR),       32'(RST_IR));
    check("rst_user_dr",  32'(USER_DR),  32'h0);
    check("rst_user_upd", 32'(USER_UPD), 32'h0);
    check("rst_tdo",      32'(TDO),      32'h0);
    check("rst_tdo_en",   32'(TDO_EN),   32'h0);

    step(0, 0);
`ifdef TAP_IDCODE_EN
    dr_scan(32, 32'h0, got);
    check("idcode_scan", got, 32'h1234_5001);
    check("idcode_ir",   32'(IR), 32'h1);
`else
    dr_scan(2, 32'b11, got);
    check("bypass_rst_scan", 32'(got[1:0]), 32'b10);
    ir_scan(4'b0001, got);
    dr_scan(2, 32'b11, got);
    check("op1_is_bypass", 32'(got[1:0]), 32'b10);
`endif

    // USER register scan
    ir_scan(4'b0010, got);
    check("ir_capture_out", 32'(got[3:0]), 32'h1);
    check("ir_user",        32'(IR),       32'h2);
    USER_CAP = 8'h3C;
    upd_seen = 0;
    dr_scan(8, 32'hA5, got);
    check("user_tdo",     32'(got[7:0]), 32'h3C);
    check("user_dr_a5",   32'(USER_DR),  32'hA5);
    check("user_upd_hi",  32'(USER_UPD), 32'h1);
    step(0, 0);
    check("user_upd_lo",  32'(USER_UPD), 32'h0);
    check("user_upd_cnt", 32'(upd_seen), 32'h1);

    // Capture, Exit1, Update with no shift: captured value is applied
    USER_CAP = 8'h5A;
    step(1, 0); step(0, 0); step(1, 0); step(1, 0); step(0, 0);
    check("cap_no_shift", 32'(USER_DR), 32'h5A);

    // Scan interrupted by a pause: pause must hold the partial shift
    USER_CAP = 8'hFF;
    pd = 8'hC3;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) step(i == 3, pd[i]);
    step(0, 0); step(0, 0); step(0, 0); step(1, 0); step(0, 0);
    for (int i = 4; i < 8; i++) step(i == 7, pd[i]);
    step(1, 0); step(0, 0);
    check("pause_scan", 32'(USER_DR), 32'hC3);

    // BYPASS via all-ones opcode
    ir_scan(4'b1111, got);
    check("ir_scan_tdo", 32'(got[3:0]), 32'b0001);
    dr_scan(4, 32'b1101, got);
    check("bypass_tdo",  32'(got[3:0]), 32'b1010);
    check("bypass_keeps_user", 32'(USER_DR), 32'hC3);

    // Five TMS=1 from SHIFT_DR reaches TLR; IR reloads on the next TLR edge
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) step(1, 0);
    check("tlr_state", 32'(STATE), 32'h0);
    step(1, 0);
    check("tlr_ir",    32'(IR),      32'(RST_IR));
    check("tlr_user",  32'(USER_DR), 32'hC3);

    // Asynchronous reset in the middle of a DR shift
    step(0, 0);
    ir_scan(4'b0010, got);
    step(1, 0); step(0, 0); step(0, 0);
    step(0, 1); step(0, 0);
    #2 TRST_N = 1'b0;
    model_reset();
    #1;
    check("arst_state",   32'(STATE),   32'h0);
    check("arst_user_dr", 32'(USER_DR), 32'h0);
    check("arst_ir",      32'(IR),      32'(RST_IR));
    check("arst_tdo_en",  32'(TDO_EN),  32'h0);
    check("arst_tdo",     32'(TDO),     32'h0);
    #1 TRST_N = 1'b1;
    step(0, 0);
    check("post_arst_rti", 32'(STATE), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtag_tap_core.md
# jtag_tap_core

Parametrised IEEE 1149.1-style TAP: the 16-state TAP controller, with its existing 4-bit state encoding, extended with a serial datapath. The datapath is a configurable instruction register, BYPASS, an optional IDCODE register and one user data register of configurable width, all driven by TDI and returning TDO. It sits between the chip's JTAG pins and on-chip debug/config logic, which sees the user DR as a parallel capture/update port.

## Interface
- IR_W, 4: instruction register width (≥2).
- DR_W, 8: user data register width (≥1).
- IDCODE_VAL, 32'h1234_5001: IDCODE contents; bit 0 must be 1.
- TCK  in  1  test clock; all state changes on posedge.
- TRST_N  in  1  asynchronous active-low reset.
- TMS  in  1  mode select, sampled on posedge TCK.
- TDI  in  1  serial data in, sampled on posedge TCK.
- USER_CAP  in  DR_W  parallel value loaded into the user shift register at Capture-DR.
- TDO  out  1  serial data out.
- TDO_EN  out  1  high while STATE is SHIFT_DR or SHIFT_IR.
- STATE  out  4  current TAP state, in the existing encoding (0000 TEST_LOGIC_RESET … 1111 UPDATE_IR).
- IR  out  IR_W  active instruction.
- USER_DR  out  DR_W  user register parallel output.
- USER_UPD  out  1  one-cycle pulse when USER_DR is written.

## Operation
- FSM: standard 1149.1 transitions on TMS. Examples: TLR –0→ RTI; RTI –1→ SEL_DR; SEL_DR –1→ SEL_IR –1→ TLR; EXITx –1→ UPDATE_x; UPDATE_x –0→ RTI, –1→ SEL_DR. Five TMS=1 cycles reach TLR from any state.
- Opcodes:
  - all-ones = BYPASS.
  - 1 = IDCODE.
  - 2 = USER.
  - Any other value selects BYPASS.
- Selected DR is decoded from IR: BYPASS (1 bit), IDCODE (32 bits), or USER (DR_W bits).
- Actions occur on the posedge at which STATE equals the named state:
  - CAPTURE_IR: IR shift register ← {zeros, 2'b01}.
  - SHIFT_IR: IR shift register ← {TDI, sr[IR_W-1:1]}.
  - UPDATE_IR: IR ← IR shift register.
  - CAPTURE_DR: the selected DR shift register loads as follows.
    - BYPASS loads 0.
    - IDCODE loads IDCODE_VAL.
    - USER loads USER_CAP.
  - SHIFT_DR: the selected register shifts right, with TDI entering at the MSB.
  - UPDATE_DR with IR=USER: USER_DR ← user shift register, and USER_UPD=1 for the next cycle.
  - TEST_LOGIC_RESET: IR ← reset instruction (synchronous, every cycle in TLR).
- TDO is combinational:
  - In SHIFT_IR: IR shift register bit 0.
  - In SHIFT_DR: bit 0 of the selected DR.
  - Otherwise: 0.
- Unselected DRs hold their contents. USER_DR changes only via UPDATE_DR with IR=USER.

## Timing
- Reset (TRST_N low, asynchronous) sets:
  - STATE=0000.
  - IR = reset instruction.
  - All shift registers = 0.
  - USER_DR=0, USER_UPD=0, TDO=0, TDO_EN=0.
- Reset mid-scan aborts immediately. The partial shift is discarded and USER_DR is untouched beyond being cleared by reset.
- Deassertion takes effect at the first posedge with TRST_N high.
- STATE: registered, 1-cycle latency from TMS.
- IR/USER_DR: update visible the cycle after the posedge in UPDATE_x.
- USER_UPD: high for exactly one TCK cycle per UPDATE_DR with IR=USER. It does not pulse for other instructions.
- BYPASS gives 1-cycle TDI→TDO delay through shift states. The first bit out after capture is 0.
- Capture then Exit1 with no Shift: registers keep their captured value, and Update applies it.
- Pause states hold all shift registers.

## Configuration
- Macro `TAP_IDCODE_EN`.
- Defined:
  - IDCODE register is present.
  - Reset instruction = 1 (IDCODE).
- Undefined:
  - No IDCODE register.
  - Opcode 1 decodes to BYPASS.
  - Reset instruction = all-ones (BYPASS).

## Test plan
- With `TAP_IDCODE_EN`, defaults: reset, TMS to SHIFT_DR with no IR scan, shift 32 cycles TDI=0 → TDO serial LSB-first = 0x12345001, IR=4'b0001.
- Load IR=4'b0010, then a DR scan with USER_CAP=8'h3C and TDI bits of 8'hA5 LSB-first → TDO yields 8'h3C, USER_DR=8'hA5 the cycle after UPDATE_DR, USER_UPD high exactly 1 cycle.
- IR scan shifting 4'b1111 → TDO during the IR shift = 1,0,0,0. Then a DR shift of TDI=1,0,1,1 → TDO=0,1,0,1.
- From SHIFT_DR, TMS=1 for 5 cycles → STATE=0000, IR back to 4'b0001, USER_DR unchanged.
- TRST_N pulsed low mid-SHIFT_DR between edges → STATE=0000 and USER_DR=0 immediately, without waiting for a TCK edge.
- Without `TAP_IDCODE_EN`: reset → IR=4'b1111. DR shift TDI=1,1 → TDO=0,1.
